// File: rtl/multdiv_issue.sv
// multdiv_issue: issue controller between the execute stage and the shared
// multiply/divide unit. It takes one request at a time, holds the operands and
// the select level steady while the unit works, and returns the result (or a
// timeout exception) to writeback as a single-cycle pulse. The pipeline is
// stalled whenever a new request cannot be taken.
module multdiv_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [15:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] md_operandA,
  output logic [15:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        wb_timeout
);

  // Counter only has to reach TIMEOUT-1 because BUSY is left on that value.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [15:0]      opb_q, opb_d;
  logic [4:0]       rd_q, rd_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_exc_q, wb_exc_d;
  logic             wb_to_q, wb_to_d;

  logic accept;
  logic timed_out;

  // A request is only taken in IDLE and never while a flush is asserted.
  assign req_ready = (state_q == S_IDLE) && !flush;
  assign stall     = !req_ready;
  assign accept    = req_valid && req_ready;
  assign timed_out = (cnt_q == CNT_LAST);

  // State register; reset returns to IDLE from any state, dropping the select.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; flush in BUSY takes priority over result and timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_GAP;
        end else if (md_resultRDY || timed_out) begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: operands latch on accept, writeback fields
  // latch on result or timeout, and the select is held only through BUSY.
  always_comb begin
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rd_d       = rd_q;
    mult_d     = 1'b0;
    div_d      = 1'b0;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_exc_d   = wb_exc_q;
    wb_to_d    = wb_to_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d  = req_a;
          opb_d  = req_b;
          rd_d   = req_rd;
          mult_d = !req_op;
          div_d  = req_op;
          cnt_d  = '0;
        end
      end
      S_BUSY: begin
        cnt_d  = cnt_q + CNT_W'(1);
        mult_d = mult_q;
        div_d  = div_q;
        if (flush) begin
          // Abort: select drops, nothing is committed.
          mult_d = 1'b0;
          div_d  = 1'b0;
        end else if (md_resultRDY) begin
          mult_d     = 1'b0;
          div_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = md_result;
          wb_rd_d    = rd_q;
          wb_exc_d   = md_exception;
          wb_to_d    = 1'b0;
        end else if (timed_out) begin
          mult_d     = 1'b0;
          div_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
          wb_rd_d    = rd_q;
          wb_exc_d   = 1'b1;
          wb_to_d    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and operand/destination latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rd_q       <= '0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_exc_q   <= 1'b0;
      wb_to_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rd_q       <= rd_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_exc_q   <= wb_exc_d;
      wb_to_q    <= wb_to_d;
    end
  end

  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign md_ctrl_MULT = mult_q;
  assign md_ctrl_DIV  = div_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_exception = wb_exc_q;
  assign wb_timeout   = wb_to_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: a main instance (TIMEOUT=64) for normal traffic and
// a second instance (TIMEOUT=8) for the timeout path.
module tb_multdiv_issue;

  localparam int TO_MAIN  = 64;
  localparam int TO_SHORT = 8;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [31:0] req_a;
  logic [15:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic [31:0] md_operandA;
  logic [15:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_timeout;

  logic        t_req_valid;
  logic        t_req_ready;
  logic [31:0] t_operandA;
  logic [15:0] t_operandB;
  logic        t_mult;
  logic        t_div;
  logic        t_rdy;
  logic        t_stall;
  logic        t_wb_valid;
  logic [4:0]  t_wb_rd;
  logic [31:0] t_wb_data;
  logic        t_wb_exception;
  logic        t_wb_timeout;

  int checks;
  int failures;

  multdiv_issue #(.TIMEOUT(TO_MAIN)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .wb_timeout(wb_timeout)
  );

  multdiv_issue #(.TIMEOUT(TO_SHORT)) dut_t (
    .clock(clock), .reset(reset),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .md_operandA(t_operandA), .md_operandB(t_operandB),
    .md_ctrl_MULT(t_mult), .md_ctrl_DIV(t_div),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(t_rdy),
    .stall(t_stall), .wb_valid(t_wb_valid), .wb_rd(t_wb_rd), .wb_data(t_wb_data),
    .wb_exception(t_wb_exception), .wb_timeout(t_wb_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behaviour of the arithmetic unit: {exception, result}.
  function automatic logic [32:0] ref_unit(input logic op, input logic [31:0] a,
                                           input logic [15:0] b);
    logic [31:0] bb;
    bb = {16'b0, b};
    if (!op) return {1'b0, a * bb};
    if (b == 16'd0) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, a / bb};
  endfunction

  // One request on the main instance; the unit answers in BUSY cycle 'lat',
  // and flush is raised in BUSY cycle 'flush_at' (0 = never).
  task automatic run_op(input logic op, input logic [31:0] a, input logic [15:0] b,
                        input logic [4:0] rd, input int lat, input int flush_at,
                        input string tag);
    logic [32:0] expv;
    int  k;
    bit  done;
    bit  flushed;
    expv = ref_unit(op, a, b);
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_ready: ready=%b stall=%b, expected ready=1 stall=0", tag, req_ready, stall);
    end
    @(negedge clock);
    req_valid = 1'b0; req_a = $urandom; req_b = 16'($urandom); req_op = ~op;
    k = 0; done = 0; flushed = 0;
    while (!done) begin
      k++;
      checks++;
      if ({md_ctrl_MULT, md_ctrl_DIV} !== {~op, op} || md_operandA !== a ||
          md_operandB !== b || stall !== 1'b1 || wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s busy cyc%0d: sel=%b%b opA=%h opB=%h stall=%b wbv=%b, expected sel=%b%b opA=%h opB=%h stall=1 wbv=0",
                 tag, k, md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, stall, wb_valid,
                 ~op, op, a, b);
      end
      if (k == lat) begin
        md_resultRDY = 1'b1;
        {md_exception, md_result} = ref_unit(md_ctrl_DIV, md_operandA, md_operandB);
      end else begin
        md_resultRDY = 1'b0;
        md_result = $urandom; md_exception = 1'($urandom);
      end
      if (k == flush_at) flush = 1'b1;
      @(negedge clock);
      if (flush) begin flushed = 1; done = 1; end
      if (k == lat) done = 1;
      flush = 1'b0; md_resultRDY = 1'b0;
    end
    if (flushed) begin
      #1;
      checks++;
      if (wb_valid !== 1'b0 || md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s flush_gap: wbv=%b sel=%b%b ready=%b, expected wbv=0 sel=00 ready=0",
                 tag, wb_valid, md_ctrl_MULT, md_ctrl_DIV, req_ready);
      end
      @(negedge clock);
      #1;
      checks++;
      if (wb_valid !== 1'b0 || req_ready !== 1'b1 || md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0) begin
        failures++;
        $display("FAIL %s flush_idle: wbv=%b ready=%b sel=%b%b, expected wbv=0 ready=1 sel=00",
                 tag, wb_valid, req_ready, md_ctrl_MULT, md_ctrl_DIV);
      end
    end else begin
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== expv[31:0] || wb_rd !== rd ||
          wb_exception !== expv[32] || wb_timeout !== 1'b0 ||
          md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0 || stall !== 1'b1) begin
        failures++;
        $display("FAIL %s wb: v=%b data=%h rd=%0d exc=%b to=%b sel=%b%b stall=%b, expected v=1 data=%h rd=%0d exc=%b to=0 sel=00 stall=1",
                 tag, wb_valid, wb_data, wb_rd, wb_exception, wb_timeout, md_ctrl_MULT,
                 md_ctrl_DIV, stall, expv[31:0], rd, expv[32]);
      end
      // Unit inputs are garbage outside BUSY and must not be captured.
      md_resultRDY = 1'b1; md_result = $urandom; md_exception = ~expv[32];
      @(negedge clock);
      md_resultRDY = 1'b0;
      #1;
      checks++;
      if (wb_valid !== 1'b0 || wb_data !== expv[31:0] || wb_rd !== rd ||
          wb_exception !== expv[32] || req_ready !== 1'b1 || stall !== 1'b0) begin
        failures++;
        $display("FAIL %s after_wb: v=%b data=%h rd=%0d exc=%b ready=%b stall=%b, expected v=0 data=%h rd=%0d exc=%b ready=1 stall=0",
                 tag, wb_valid, wb_data, wb_rd, wb_exception, req_ready, stall,
                 expv[31:0], rd, expv[32]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_rd, wb_data,
         wb_exception, wb_timeout} !== '0 || req_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: sel=%b%b opA=%h opB=%h wbv=%b rd=%0d data=%h exc=%b to=%b ready=%b stall=%b, expected all 0 ready=1 stall=0",
               md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_rd, wb_data,
               wb_exception, wb_timeout, req_ready, stall);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush_stall: stall=%b ready=%b, expected stall=1 ready=0", stall, req_ready);
    end
    flush = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0 || md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b wbv=%b sel=%b%b, expected ready=1 wbv=0 sel=00",
               req_ready, wb_valid, md_ctrl_MULT, md_ctrl_DIV);
    end
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd7, 16'd6, 5'd5, 16, 0, "mult");
  endtask

  task automatic test_div_zero();
    run_op(1'b1, 32'd100, 16'd0, 5'd9, 32, 0, "divzero");
  endtask

  task automatic test_flush_busy();
    run_op(1'b0, 32'd1234, 16'd77, 5'd3, 3, 3, "flush_busy");
  endtask

  // Timeout instance; with rdy_last the unit answers in the last allowed cycle.
  task automatic test_timeout(input bit rdy_last);
    logic [31:0] a, val;
    logic [15:0] b;
    logic [4:0]  rd;
    logic        op;
    int          k;
    bit          done;
    a = $urandom; b = 16'($urandom); rd = 5'($urandom); op = 1'($urandom); val = $urandom;
    req_op = op; req_a = a; req_b = b; req_rd = rd; t_req_valid = 1'b1;
    #1;
    checks++;
    if (t_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_ready: ready=%b, expected 1", t_req_ready);
    end
    @(negedge clock);
    t_req_valid = 1'b0;
    k = 0; done = 0;
    while (!done) begin
      k++;
      checks++;
      if ({t_mult, t_div} !== {~op, op} || t_operandA !== a || t_operandB !== b ||
          t_stall !== 1'b1 || t_wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL timeout busy cyc%0d: sel=%b%b opA=%h opB=%h stall=%b wbv=%b, expected sel=%b%b opA=%h opB=%h stall=1 wbv=0",
                 k, t_mult, t_div, t_operandA, t_operandB, t_stall, t_wb_valid, ~op, op, a, b);
      end
      if (rdy_last && k == TO_SHORT) begin
        t_rdy = 1'b1; md_result = val; md_exception = 1'b0;
      end
      @(negedge clock);
      t_rdy = 1'b0;
      if (t_wb_valid === 1'b1 || k >= TO_SHORT + 4) done = 1;
    end
    checks++;
    if (k != TO_SHORT) begin
      failures++;
      $display("FAIL timeout_len: busy cycles=%0d, expected %0d", k, TO_SHORT);
    end
    checks++;
    if (t_wb_valid !== 1'b1 || t_wb_rd !== rd ||
        t_wb_data !== (rdy_last ? val : 32'd0) || t_wb_exception !== ~rdy_last ||
        t_wb_timeout !== ~rdy_last || t_mult !== 1'b0 || t_div !== 1'b0) begin
      failures++;
      $display("FAIL timeout_wb(rdy_last=%0d): v=%b rd=%0d data=%h exc=%b to=%b sel=%b%b, expected v=1 rd=%0d data=%h exc=%b to=%b sel=00",
               rdy_last, t_wb_valid, t_wb_rd, t_wb_data, t_wb_exception, t_wb_timeout, t_mult, t_div,
               rd, rdy_last ? val : 32'd0, ~rdy_last, ~rdy_last);
    end
    @(negedge clock);
    checks++;
    if (t_wb_valid !== 1'b0 || t_req_ready !== 1'b1 || t_wb_timeout !== ~rdy_last) begin
      failures++;
      $display("FAIL timeout_after: v=%b ready=%b to=%b, expected v=0 ready=1 to=%b",
               t_wb_valid, t_req_ready, t_wb_timeout, ~rdy_last);
    end
  endtask

  task automatic test_flush_idle();
    req_valid = 1'b1; flush = 1'b1; req_a = $urandom; req_op = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_stall: stall=%b ready=%b, expected stall=1 ready=0", stall, req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_noaccept: sel=%b%b stall=%b, expected sel=00 stall=0",
               md_ctrl_MULT, md_ctrl_DIV, stall);
    end
  endtask

  // Two requests offered with req_valid held; unit answers in the first BUSY cycle.
  task automatic test_back_to_back();
    logic        op_l[2];
    logic [31:0] a_l[2];
    logic [15:0] b_l[2];
    logic [4:0]  rd_l[2];
    logic [32:0] exp_l[2];
    int          wb_cyc[$];
    int          idx, nwb, phase, gap;
    bit          acc, sel;
    for (int i = 0; i < 2; i++) begin
      op_l[i] = 1'($urandom); a_l[i] = $urandom; b_l[i] = 16'($urandom_range(1, 65535));
      rd_l[i] = 5'($urandom); exp_l[i] = ref_unit(op_l[i], a_l[i], b_l[i]);
    end
    idx = 0; nwb = 0; phase = 0; gap = 0;
    req_valid = 1'b1; req_op = op_l[0]; req_a = a_l[0]; req_b = b_l[0]; req_rd = rd_l[0];
    for (int cyc = 0; cyc < 10; cyc++) begin
      sel = md_ctrl_MULT | md_ctrl_DIV;
      md_resultRDY = sel;
      if (sel) {md_exception, md_result} = ref_unit(md_ctrl_DIV, md_operandA, md_operandB);
      else begin md_result = $urandom; md_exception = 1'($urandom); end
      checks++;
      if (md_ctrl_MULT === 1'b1 && md_ctrl_DIV === 1'b1) begin
        failures++;
        $display("FAIL b2b_both_sel cyc%0d: sel=11, expected at most one high", cyc);
      end
      if (phase == 0 && sel) phase = 1;
      else if (phase == 1 && !sel) begin phase = 2; gap = 1; end
      else if (phase == 2) begin if (sel) phase = 3; else gap++; end
      if (wb_valid === 1'b1) begin
        if (nwb < 2) begin
          checks++;
          if (wb_data !== exp_l[nwb][31:0] || wb_rd !== rd_l[nwb] || wb_exception !== exp_l[nwb][32]) begin
            failures++;
            $display("FAIL b2b_wb%0d: data=%h rd=%0d exc=%b, expected data=%h rd=%0d exc=%b",
                     nwb, wb_data, wb_rd, wb_exception, exp_l[nwb][31:0], rd_l[nwb], exp_l[nwb][32]);
          end
        end
        wb_cyc.push_back(cyc);
        nwb++;
      end
      acc = req_valid && req_ready;
      @(negedge clock);
      if (acc) begin
        idx++;
        if (idx < 2) begin
          req_op = op_l[idx]; req_a = a_l[idx]; req_b = b_l[idx]; req_rd = rd_l[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    md_resultRDY = 1'b0; req_valid = 1'b0;
    checks++;
    if (wb_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulses: count=%0d, expected 2", wb_cyc.size());
    end else if (wb_cyc[0] != 2 || wb_cyc[1] != 5) begin
      failures++;
      $display("FAIL b2b_spacing: pulses at cycles %0d,%0d, expected 2,5", wb_cyc[0], wb_cyc[1]);
    end
    checks++;
    if (phase != 3 || gap < 1) begin
      failures++;
      $display("FAIL b2b_sel_gap: phase=%0d gap=%0d, expected second select after >=1 low cycle", phase, gap);
    end
  endtask

  task automatic test_random();
    logic        op;
    logic [31:0] a;
    logic [15:0] b;
    logic [4:0]  rd;
    int          lat, fa;
    for (int i = 0; i < 8; i++) begin
      op = 1'($urandom); a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      rd = 5'($urandom); lat = $urandom_range(1, 30);
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0;
      run_op(op, a, b, rd, lat, fa, "random");
    end
  endtask

  task automatic test_reset_mid_busy();
    req_op = 1'b1; req_a = $urandom; req_b = 16'($urandom); req_rd = 5'($urandom);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; md_resultRDY = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (md_ctrl_DIV !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy_pre: div=%b, expected 1", md_ctrl_DIV);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_rd, wb_data,
         wb_exception, wb_timeout} !== '0 || req_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: sel=%b%b opA=%h opB=%h wbv=%b rd=%0d data=%h exc=%b to=%b ready=%b, expected all 0 ready=1",
               md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_rd, wb_data,
               wb_exception, wb_timeout, req_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (wb_valid !== 1'b0 || md_ctrl_DIV !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release: wbv=%b div=%b ready=%b, expected 0 0 1", wb_valid, md_ctrl_DIV, req_ready);
    end
    run_op(1'b0, $urandom, 16'($urandom), 5'($urandom), 5, 0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    t_req_valid = 1'b0; t_rdy = 1'b0;
    test_reset();
    test_mult();
    test_div_zero();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_flush_busy();
    test_flush_idle();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
